// File: rtl/iobus_input_port.sv
// iobus_input_port
// IOBUS responder for the board input devices (slide switches, push buttons).
//  - 2-flop synchronizer on every switch and button bit.
//  - Per-button debounce: a level change is accepted only after DB_CYCLES
//    consecutive differing synchronized samples.
//  - Debounced rising edges set sticky pending flags (write-1-to-clear).
//  - INTR = registered OR of (pending & mask).
// Optional build macro: IOBUS_INTR_PULSE_EN
//  - undefined (default): INTR is a level that follows |(PEND & MASK).
//  - defined: INTR is a one-cycle pulse whenever any PEND & MASK bit goes 0->1.
//
// Bus semantics: there is no handshake. A read is purely combinational
// from registered state, so IOBUS_IN is valid in the same cycle IOBUS_ADDR
// is presented. A write is taken on the rising CLK edge where IOBUS_WR=1,
// and the addressed register holds the new value from the following cycle.
module iobus_input_port #(
   parameter int DB_CYCLES = 8,
   parameter int NUM_BTN   = 5
) (
   input  logic               CLK,
   input  logic               RESET_N,
   input  logic [15:0]        SWITCHES,
   input  logic [NUM_BTN-1:0] BUTTONS,
   input  logic [31:0]        IOBUS_ADDR,
   input  logic [31:0]        IOBUS_OUT,
   input  logic               IOBUS_WR,
   output logic [31:0]        IOBUS_IN,
   output logic               INTR
);

   localparam int             CW      = $clog2(DB_CYCLES + 1);
   localparam logic [CW-1:0]  DB_LAST = CW'(DB_CYCLES - 1);

   localparam logic [31:0] ADDR_SW       = 32'h1100_8000;
   localparam logic [31:0] ADDR_BTN      = 32'h1100_8004;
   localparam logic [31:0] ADDR_PEND     = 32'h1100_8008;
   localparam logic [31:0] ADDR_MASK_RD  = 32'h1100_800C;
   localparam logic [31:0] ADDR_PEND_CLR = 32'h1100_C010;
   localparam logic [31:0] ADDR_MASK_WR  = 32'h1100_C014;

   // synchronizer stages
   logic [15:0]        sw_meta;
   logic [15:0]        sw_sync;
   logic [NUM_BTN-1:0] btn_meta;
   logic [NUM_BTN-1:0] btn_sync;

   // debounce state
   logic [NUM_BTN-1:0][CW-1:0] db_cnt;
   logic [NUM_BTN-1:0][CW-1:0] db_cnt_nxt;
   logic [NUM_BTN-1:0]         btn_stable;
   logic [NUM_BTN-1:0]         btn_stable_nxt;

   // event / interrupt state
   logic [NUM_BTN-1:0] btn_rise;
   logic [NUM_BTN-1:0] pend;
   logic [NUM_BTN-1:0] pend_nxt;
   logic [NUM_BTN-1:0] pend_clr;
   logic [NUM_BTN-1:0] mask;
   logic [NUM_BTN-1:0] pend_masked;
   logic               wr_pend_clr;
   logic               wr_mask;

   // Upper write-data bits are never used by this responder.
   logic unused_wdata;
   assign unused_wdata = ^IOBUS_OUT[31:NUM_BTN];

   // Two-flop synchronizers for all asynchronous board inputs.
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         sw_meta  <= '0;
         sw_sync  <= '0;
         btn_meta <= '0;
         btn_sync <= '0;
      end else begin
         sw_meta  <= SWITCHES;
         sw_sync  <= sw_meta;
         btn_meta <= BUTTONS;
         btn_sync <= btn_meta;
      end
   end

   // Debounce next-state: count differing samples, accept on the last one.
   always_comb begin
      btn_stable_nxt = btn_stable;
      db_cnt_nxt     = '0;
      for (int i = 0; i < NUM_BTN; i++) begin
         if (btn_sync[i] != btn_stable[i]) begin
            if (db_cnt[i] == DB_LAST) begin
               btn_stable_nxt[i] = btn_sync[i];
            end else begin
               db_cnt_nxt[i] = db_cnt[i] + CW'(1);
            end
         end
      end
   end

   // Debounce state registers.
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         db_cnt     <= '0;
         btn_stable <= '0;
      end else begin
         db_cnt     <= db_cnt_nxt;
         btn_stable <= btn_stable_nxt;
      end
   end

   // Rising edges are taken from the debounced next state so a pending flag
   // sets on the same edge the debounced level changes.
   assign btn_rise    = btn_stable_nxt & ~btn_stable;
   assign wr_pend_clr = IOBUS_WR && (IOBUS_ADDR == ADDR_PEND_CLR);
   assign wr_mask     = IOBUS_WR && (IOBUS_ADDR == ADDR_MASK_WR);
   assign pend_clr    = wr_pend_clr ? IOBUS_OUT[NUM_BTN-1:0] : '0;
   // A rise in the same cycle as a clear of that bit wins.
   assign pend_nxt    = (pend & ~pend_clr) | btn_rise;

   // Pending flags and interrupt mask.
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         pend <= '0;
         mask <= '0;
      end else begin
         pend <= pend_nxt;
         if (wr_mask) begin
            mask <= IOBUS_OUT[NUM_BTN-1:0];
         end
      end
   end

   assign pend_masked = pend & mask;

`ifdef IOBUS_INTR_PULSE_EN
   logic [NUM_BTN-1:0] pend_masked_q;

   // Pulse mode: one INTR cycle for each new masked pending bit.
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         pend_masked_q <= '0;
         INTR          <= 1'b0;
      end else begin
         pend_masked_q <= pend_masked;
         INTR          <= |(pend_masked & ~pend_masked_q);
      end
   end
`else
   // Level mode: INTR follows any masked pending bit, one cycle later.
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         INTR <= 1'b0;
      end else begin
         INTR <= |pend_masked;
      end
   end
`endif

   // Read mux, combinational from registered state.
   always_comb begin
      IOBUS_IN = '0;
      case (IOBUS_ADDR)
         ADDR_SW:      IOBUS_IN[15:0]        = sw_sync;
         ADDR_BTN:     IOBUS_IN[NUM_BTN-1:0] = btn_stable;
         ADDR_PEND:    IOBUS_IN[NUM_BTN-1:0] = pend;
         ADDR_MASK_RD: IOBUS_IN[NUM_BTN-1:0] = mask;
         default:      IOBUS_IN              = '0;
      endcase
   end

endmodule

// File: tb/tb_iobus_input_port.sv
// Directed bench for iobus_input_port (DB_CYCLES=8, NUM_BTN=5).
// Expected INTR values depend on IOBUS_INTR_PULSE_EN where modes differ.
module tb_iobus_input_port;

   localparam logic [31:0] A_SW    = 32'h1100_8000;
   localparam logic [31:0] A_BTN   = 32'h1100_8004;
   localparam logic [31:0] A_PEND  = 32'h1100_8008;
   localparam logic [31:0] A_MASK  = 32'h1100_800C;
   localparam logic [31:0] A_UNMAP = 32'h1100_8010;
   localparam logic [31:0] A_CLR   = 32'h1100_C010;
   localparam logic [31:0] A_MSKW  = 32'h1100_C014;

`ifdef IOBUS_INTR_PULSE_EN
   localparam logic PULSE = 1'b1;
`else
   localparam logic PULSE = 1'b0;
`endif
   // INTR expected while a masked bit stays pending (after its first cycle)
   localparam logic [31:0] HOLD_INTR = PULSE ? 32'd0 : 32'd1;

   logic        CLK = 1'b0;
   logic        RESET_N;
   logic [15:0] SWITCHES;
   logic [4:0]  BUTTONS;
   logic [31:0] IOBUS_ADDR;
   logic [31:0] IOBUS_OUT;
   logic        IOBUS_WR;
   logic [31:0] IOBUS_IN;
   logic        INTR;

   int n_cmp = 0;
   int n_err = 0;

   iobus_input_port #(.DB_CYCLES(8), .NUM_BTN(5)) dut (
      .CLK(CLK), .RESET_N(RESET_N), .SWITCHES(SWITCHES), .BUTTONS(BUTTONS),
      .IOBUS_ADDR(IOBUS_ADDR), .IOBUS_OUT(IOBUS_OUT), .IOBUS_WR(IOBUS_WR),
      .IOBUS_IN(IOBUS_IN), .INTR(INTR)
   );

   // clock
   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // advance n rising edges, return 1 ns after the last one
   task automatic step(input int n);
      repeat (n) @(posedge CLK);
      #1;
   endtask

   task automatic rd_chk(input string tag, input logic [31:0] addr, input logic [31:0] exp);
      IOBUS_ADDR = addr;
      #1;
      check(tag, IOBUS_IN, exp);
   endtask

   task automatic bus_wr(input logic [31:0] addr, input logic [31:0] data);
      IOBUS_ADDR = addr;
      IOBUS_OUT  = data;
      IOBUS_WR   = 1'b1;
      @(posedge CLK);
      #1;
      IOBUS_WR   = 1'b0;
      IOBUS_OUT  = '0;
   endtask

   initial begin
      RESET_N = 1'b0; SWITCHES = '0; BUTTONS = '0;
      IOBUS_ADDR = '0; IOBUS_OUT = '0; IOBUS_WR = 1'b0;
      step(2);
      check("rst_intr", {31'd0, INTR}, 32'd0);
      rd_chk("rst_pend", A_PEND, 32'd0);
      RESET_N = 1'b1;
      step(1);

      // --- asynchronous reset with every input high ---
      SWITCHES = 16'hFFFF; BUTTONS = 5'h1F;
      IOBUS_OUT = 32'hFFFF_FFFF; IOBUS_ADDR = 32'hFFFF_FFFF; IOBUS_WR = 1'b1;
      step(3);
      rd_chk("pre_rst_sw", A_SW, 32'h0000_FFFF);
      RESET_N = 1'b0;
      #1;
      check("async_rst_intr", {31'd0, INTR}, 32'd0);
      rd_chk("async_rst_sw", A_SW, 32'd0);
      rd_chk("async_rst_btn", A_BTN, 32'd0);
      rd_chk("async_rst_pend", A_PEND, 32'd0);
      rd_chk("async_rst_mask", A_MASK, 32'd0);
      SWITCHES = '0; BUTTONS = '0; IOBUS_OUT = '0; IOBUS_WR = 1'b0; IOBUS_ADDR = '0;
      step(1);
      RESET_N = 1'b1;
      step(12);
      rd_chk("post_rst_btn", A_BTN, 32'd0);
      rd_chk("post_rst_pend", A_PEND, 32'd0);

      // --- switch synchronizer latency ---
      SWITCHES = 16'hA5C3;
      rd_chk("sw_c0", A_SW, 32'd0);
      step(1);
      rd_chk("sw_c1", A_SW, 32'd0);
      step(1);
      rd_chk("sw_c2", A_SW, 32'h0000_A5C3);
      step(1);
      rd_chk("sw_c3", A_SW, 32'h0000_A5C3);
      rd_chk("unmapped", A_UNMAP, 32'd0);

      // --- 5-cycle glitch on BUTTONS[2] is rejected ---
      BUTTONS = 5'b00100;
      step(5);
      BUTTONS = 5'b00000;
      step(12);
      rd_chk("glitch_btn", A_BTN, 32'd0);
      rd_chk("glitch_pend", A_PEND, 32'd0);

      // --- held press: stable after 2+8 edges ---
      BUTTONS = 5'b00100;
      step(9);
      rd_chk("press_btn_e9", A_BTN, 32'd0);
      rd_chk("press_pend_e9", A_PEND, 32'd0);
      step(1);
      rd_chk("press_btn_e10", A_BTN, 32'h4);
      rd_chk("press_pend_e10", A_PEND, 32'h4);
      BUTTONS = 5'b00000;
      step(10);
      rd_chk("release_btn", A_BTN, 32'd0);
      rd_chk("release_pend", A_PEND, 32'h4);
      check("unmasked_intr", {31'd0, INTR}, 32'd0);

      // --- mask a pending bit, then clear it ---
      bus_wr(A_MSKW, 32'h0000_0004);
      rd_chk("mask_rd", A_MASK, 32'h4);
      check("mask_intr_c0", {31'd0, INTR}, 32'd0);
      step(1);
      check("mask_intr_c1", {31'd0, INTR}, 32'd1);
      step(1);
      check("mask_intr_c2", {31'd0, INTR}, HOLD_INTR);
      bus_wr(A_CLR, 32'h0000_0004);
      rd_chk("clr_pend", A_PEND, 32'd0);
      check("clr_intr_c0", {31'd0, INTR}, HOLD_INTR);
      step(1);
      check("clr_intr_c1", {31'd0, INTR}, 32'd0);

      // --- collision: set of bit 0 wins over its clear, bit 1 still clears ---
      BUTTONS = 5'b00010;
      step(10);
      rd_chk("btn1_pend", A_PEND, 32'h2);
      BUTTONS = 5'b00000;
      step(10);
      BUTTONS = 5'b00001;
      step(9);
      bus_wr(A_CLR, 32'h0000_0003);
      rd_chk("coll_btn", A_BTN, 32'h1);
      rd_chk("coll_pend", A_PEND, 32'h1);
      check("coll_intr", {31'd0, INTR}, 32'd0);
      bus_wr(A_CLR, 32'h0000_0001);
      rd_chk("coll_clr_pend", A_PEND, 32'd0);
      BUTTONS = 5'b00000;
      step(10);
      rd_chk("coll_rel_btn", A_BTN, 32'd0);

      // --- all masked: one press, then a second press while first pending ---
      bus_wr(A_MSKW, 32'h0000_001F);
      rd_chk("mask_all_rd", A_MASK, 32'h1F);
      BUTTONS = 5'b00001;
      step(9);
      check("p0_intr_e9", {31'd0, INTR}, 32'd0);
      step(1);
      rd_chk("p0_pend", A_PEND, 32'h1);
      check("p0_intr_e10", {31'd0, INTR}, 32'd0);
      step(1);
      check("p0_intr_e11", {31'd0, INTR}, 32'd1);
      step(1);
      check("p0_intr_e12", {31'd0, INTR}, HOLD_INTR);
      BUTTONS = 5'b00011;
      step(10);
      rd_chk("p1_pend", A_PEND, 32'h3);
      check("p1_intr_e10", {31'd0, INTR}, HOLD_INTR);
      step(1);
      check("p1_intr_e11", {31'd0, INTR}, 32'd1);
      step(1);
      check("p1_intr_e12", {31'd0, INTR}, HOLD_INTR);
      step(3);
      check("both_pend_intr", {31'd0, INTR}, HOLD_INTR);
      bus_wr(A_CLR, 32'h0000_001F);
      rd_chk("final_pend", A_PEND, 32'd0);
      step(1);
      check("final_intr", {31'd0, INTR}, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
